// File: rtl/spi_master_controller.sv
// SPI master, mode 0 (CPOL=0, CPHA=0), LSB-first, full duplex.
// One parallel word is accepted over a valid/ready handshake, shifted out on
// mosi while miso is captured, and the received word is returned with a
// single-cycle rxValid pulse. Every FSM state lasts CLK_DIV clk cycles.
module spi_master_controller #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 5
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [WIDTH-1:0] txData,
  input  logic             txValid,
  output logic             txReady,
  output logic [WIDTH-1:0] rxData,
  output logic             rxValid,
  output logic             busy,
  output logic             sclk,
  output logic             csN,
  output logic             mosi,
  input  logic             miso
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    GAP
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             sclk_q, sclk_d;
  logic             csn_q, csn_d;

  logic div_done;
  logic tx_ready;
  logic accept;

  // The last GAP cycle already counts as ready so that a held txValid starts
  // the next frame with csN high for exactly CLK_DIV cycles.
  assign div_done = (div_q == DIV_LAST);
  assign tx_ready = (state_q == IDLE) || ((state_q == GAP) && div_done);
  assign accept   = txValid && tx_ready;

  // Next-state, divider, counters and shift registers for one frame.
  always_comb begin
    state_d    = state_q;
    div_d      = div_done ? '0 : div_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (accept) begin
          state_d    = SETUP;
          tx_shift_d = txData;
          bit_cnt_d  = '0;
        end
      end
      SETUP: begin
        if (div_done) begin
          state_d    = HIGH;
          rx_shift_d = {miso, rx_shift_q[WIDTH-1:1]};
          bit_cnt_d  = bit_cnt_q + 1'b1;
        end
      end
      HIGH: begin
        // Zeros fill from the top, so mosi reads 0 once the last bit is gone.
        if (div_done) begin
          state_d    = LOW;
          tx_shift_d = {1'b0, tx_shift_q[WIDTH-1:1]};
        end
      end
      LOW: begin
        if (div_done) begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d    = GAP;
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
          end else begin
            state_d    = HIGH;
            rx_shift_d = {miso, rx_shift_q[WIDTH-1:1]};
            bit_cnt_d  = bit_cnt_q + 1'b1;
          end
        end
      end
      GAP: begin
        if (div_done) begin
          if (accept) begin
            state_d    = SETUP;
            tx_shift_d = txData;
            bit_cnt_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    sclk_d = (state_d == HIGH);
    csn_d  = !((state_d == SETUP) || (state_d == HIGH) || (state_d == LOW));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and registered serial outputs; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      div_q      <= '0;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      sclk_q     <= 1'b0;
      csn_q      <= 1'b1;
    end else begin
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sclk_q     <= sclk_d;
      csn_q      <= csn_d;
    end
  end

  assign txReady = tx_ready;
  assign busy    = !tx_ready;
  assign sclk    = sclk_q;
  assign csN     = csn_q;
  assign mosi    = tx_shift_q[0];
  assign rxData  = rx_data_q;
  assign rxValid = rx_valid_q;

endmodule

// File: tb/tb_spi_master_controller.sv
// Bench for spi_master_controller: four instances with different WIDTH and
// CLK_DIV, a behavioural mode-0 slave on instance 1, loopback on the others,
// and a passive monitor that measures the serial waveform.
module tb_spi_master_controller;

  localparam int NI = 4;

  function automatic int w_of(input int g);
    return (g == 3) ? 2 : 8;
  endfunction

  function automatic int d_of(input int g);
    case (g)
      0:       return 5;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  logic          clk = 1'b0;
  logic [NI-1:0] rst_n = '1;
  logic [NI-1:0] tx_valid = '0;
  logic [7:0]    tx_data [NI] = '{default: 8'h00};
  logic [NI-1:0] tx_ready_w, busy_w, sclk_w, csn_w, mosi_w, miso_w, rxv_w;
  logic [7:0]    rx_data [NI];

  logic [7:0] slave_q;
  logic [7:0] slave_init = 8'h00;
  logic       slave_load = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = w_of(g);
    localparam int D = d_of(g);
    logic [W-1:0] rxd;
    spi_master_controller #(.WIDTH(W), .CLK_DIV(D)) u_dut (
      .clk     (clk),
      .resetN  (rst_n[g]),
      .txData  (tx_data[g][W-1:0]),
      .txValid (tx_valid[g]),
      .txReady (tx_ready_w[g]),
      .rxData  (rxd),
      .rxValid (rxv_w[g]),
      .busy    (busy_w[g]),
      .sclk    (sclk_w[g]),
      .csN     (csn_w[g]),
      .mosi    (mosi_w[g]),
      .miso    (miso_w[g])
    );
    assign rx_data[g] = 8'(rxd);
    if (g == 1) begin : g_slave
      assign miso_w[g] = slave_q[0];
    end else begin : g_loop
      assign miso_w[g] = mosi_w[g];
    end
  end

  // Mode-0 slave: presents its LSB, captures mosi on each sclk rise.
  always @(posedge sclk_w[1] or posedge slave_load) begin
    if (slave_load) slave_q <= slave_init;
    else            slave_q <= {mosi_w[1], slave_q[7:1]};
  end

  // Waveform monitor, sampled on the falling clk edge.
  int         rises [NI]       = '{default: 0};
  int         falls [NI]       = '{default: 0};
  int         rxv_cnt [NI]     = '{default: 0};
  int         cs_low_run [NI]  = '{default: 0};
  int         last_low [NI]    = '{default: 0};
  int         cs_high_run [NI] = '{default: 0};
  int         last_high [NI]   = '{default: 0};
  int         since_rise [NI]  = '{default: 0};
  int         last_period [NI] = '{default: 0};
  int         mosi_viol [NI]   = '{default: 0};
  logic [7:0] mosi_bits [NI]   = '{default: 8'h00};
  logic [7:0] rx_hist0 [NI]    = '{default: 8'h00};
  logic [7:0] rx_hist1 [NI]    = '{default: 8'h00};
  logic       prev_sclk [NI]   = '{default: 1'b0};
  logic       prev_csn [NI]    = '{default: 1'b1};
  logic       prev_mosi [NI]   = '{default: 1'b0};

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (csn_w[g] === 1'b0) begin
        cs_low_run[g] <= cs_low_run[g] + 1;
        if (prev_csn[g]) last_high[g] <= cs_high_run[g];
        cs_high_run[g] <= 0;
      end else begin
        cs_high_run[g] <= cs_high_run[g] + 1;
        if (!prev_csn[g]) last_low[g] <= cs_low_run[g];
        cs_low_run[g] <= 0;
      end
      if (sclk_w[g] && !prev_sclk[g]) begin
        rises[g]       <= rises[g] + 1;
        mosi_bits[g]   <= {mosi_w[g], mosi_bits[g][7:1]};
        last_period[g] <= since_rise[g];
        since_rise[g]  <= 1;
      end else begin
        since_rise[g] <= since_rise[g] + 1;
      end
      if (!sclk_w[g] && prev_sclk[g]) falls[g] <= falls[g] + 1;
      if ((mosi_w[g] !== prev_mosi[g]) && sclk_w[g]) mosi_viol[g] <= mosi_viol[g] + 1;
      if (rxv_w[g]) begin
        rxv_cnt[g]  <= rxv_cnt[g] + 1;
        rx_hist1[g] <= rx_hist0[g];
        rx_hist0[g] <= rx_data[g];
      end
      prev_sclk[g] <= sclk_w[g];
      prev_csn[g]  <= csn_w[g];
      prev_mosi[g] <= mosi_w[g];
    end
  end

  // Stimulus helpers (no checking): start a frame, wait for rxValid, wait idle.
  task automatic start_frame(input int g, input logic [7:0] word, output bit ok);
    @(negedge clk);
    tx_data[g]  = word;
    tx_valid[g] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (tx_ready_w[g]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rxv(input int g, input int base, input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rxv_cnt[g] - base >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int g);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_ready_w[g] && csn_w[g] && !busy_w[g]) break;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic preload_slave(input logic [7:0] v);
    slave_init = v;
    slave_load = 1'b1;
    #1;
    slave_load = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      tests++;
      if ({tx_ready_w[g], busy_w[g], sclk_w[g], csn_w[g], mosi_w[g], rxv_w[g]} !== 6'b100100) begin
        fails++;
        $display("FAIL reset_ctrl[%0d]: got ready,busy,sclk,csn,mosi,rxv=%b want 100100", g,
                 {tx_ready_w[g], busy_w[g], sclk_w[g], csn_w[g], mosi_w[g], rxv_w[g]});
      end
      tests++;
      if (rx_data[g] !== 8'h00) begin
        fails++;
        $display("FAIL reset_rxdata[%0d]: got %h want 00", g, rx_data[g]);
      end
    end
    rst_n = '1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_loopback_a5();
    int r0 = rises[0], f0 = falls[0], v0 = rxv_cnt[0], m0 = mosi_viol[0];
    bit ok1, ok2;
    start_frame(0, 8'hA5, ok1);
    tx_valid[0] = 1'b0;
    wait_rxv(0, v0, 1, ok2);
    wait_idle(0);
    tests++;
    if ({ok1, ok2} !== 2'b11) begin fails++; $display("FAIL a5_timeout: got %b want 11", {ok1, ok2}); end
    tests++;
    if (rx_data[0] !== 8'hA5) begin fails++; $display("FAIL a5_rxdata: got %h want a5", rx_data[0]); end
    tests++;
    if (mosi_bits[0] !== 8'hA5) begin fails++; $display("FAIL a5_mosi_seq: got %h want a5", mosi_bits[0]); end
    tests++;
    if (rxv_cnt[0] - v0 !== 1) begin fails++; $display("FAIL a5_rxvalid_pulses: got %0d want 1", rxv_cnt[0] - v0); end
    tests++;
    if (last_low[0] !== 85) begin fails++; $display("FAIL a5_csn_low: got %0d want 85", last_low[0]); end
    tests++;
    if ({rises[0] - r0, falls[0] - f0} !== {32'd8, 32'd8}) begin
      fails++; $display("FAIL a5_edges: got rises %0d falls %0d want 8 8", rises[0] - r0, falls[0] - f0);
    end
    tests++;
    if (last_period[0] !== 10) begin fails++; $display("FAIL a5_period: got %0d want 10", last_period[0]); end
    tests++;
    if (mosi_viol[0] - m0 !== 0) begin fails++; $display("FAIL a5_mosi_while_high: got %0d want 0", mosi_viol[0] - m0); end
  endtask

  task automatic test_slave();
    int r0 = rises[1], v0 = rxv_cnt[1];
    bit ok1, ok2;
    preload_slave(8'h3C);
    start_frame(1, 8'hC3, ok1);
    tx_valid[1] = 1'b0;
    wait_rxv(1, v0, 1, ok2);
    wait_idle(1);
    tests++;
    if ({ok1, ok2} !== 2'b11) begin fails++; $display("FAIL slave_timeout: got %b want 11", {ok1, ok2}); end
    tests++;
    if (rx_data[1] !== 8'h3C) begin fails++; $display("FAIL slave_rxdata: got %h want 3c", rx_data[1]); end
    tests++;
    if (slave_q !== 8'hC3) begin fails++; $display("FAIL slave_received: got %h want c3", slave_q); end
    tests++;
    if (last_low[1] !== 34) begin fails++; $display("FAIL slave_csn_low: got %0d want 34", last_low[1]); end
    tests++;
    if (last_period[1] !== 4) begin fails++; $display("FAIL slave_period: got %0d want 4", last_period[1]); end
    tests++;
    if (rises[1] - r0 !== 8) begin fails++; $display("FAIL slave_rises: got %0d want 8", rises[1] - r0); end
  endtask

  task automatic test_reset_midframe();
    int r0 = rises[1], v0;
    bit ok1, ok2, ok3;
    preload_slave(8'h55);
    start_frame(1, 8'hE7, ok1);
    tx_valid[1] = 1'b0;
    ok2 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rises[1] - r0 >= 3) begin ok2 = 1'b1; break; end
    end
    v0 = rxv_cnt[1];
    #2 rst_n[1] = 1'b0;
    #1;
    tests++;
    if ({ok1, ok2} !== 2'b11) begin fails++; $display("FAIL midrst_timeout: got %b want 11", {ok1, ok2}); end
    tests++;
    if ({csn_w[1], sclk_w[1], mosi_w[1], tx_ready_w[1], busy_w[1]} !== 5'b10010) begin
      fails++;
      $display("FAIL midrst_outputs: got csn,sclk,mosi,ready,busy=%b want 10010",
               {csn_w[1], sclk_w[1], mosi_w[1], tx_ready_w[1], busy_w[1]});
    end
    repeat (6) @(negedge clk);
    rst_n[1] = 1'b1;
    repeat (40) @(negedge clk);
    tests++;
    if (rxv_cnt[1] - v0 !== 0) begin fails++; $display("FAIL midrst_no_rxvalid: got %0d pulses want 0", rxv_cnt[1] - v0); end
    tests++;
    if (tx_ready_w[1] !== 1'b1) begin fails++; $display("FAIL midrst_ready: got %b want 1", tx_ready_w[1]); end
    preload_slave(8'h69);
    v0 = rxv_cnt[1];
    start_frame(1, 8'h96, ok1);
    tx_valid[1] = 1'b0;
    wait_rxv(1, v0, 1, ok3);
    wait_idle(1);
    tests++;
    if ({ok1, ok3} !== 2'b11) begin fails++; $display("FAIL midrst_recover_timeout: got %b want 11", {ok1, ok3}); end
    tests++;
    if (rx_data[1] !== 8'h69 || slave_q !== 8'h96 || last_low[1] !== 34) begin
      fails++;
      $display("FAIL midrst_recover: got rx %h slave %h low %0d want 69 96 34", rx_data[1], slave_q, last_low[1]);
    end
  endtask

  task automatic test_back_to_back();
    int v0 = rxv_cnt[2];
    bit ok1, ok2, ok3;
    start_frame(2, 8'h01, ok1);
    tx_data[2] = 8'h80;
    ok2 = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_ready_w[2]) begin ok2 = 1'b1; break; end
    end
    @(posedge clk);
    #1 tx_valid[2] = 1'b0;
    wait_rxv(2, v0, 2, ok3);
    wait_idle(2);
    repeat (20) @(negedge clk);
    tests++;
    if ({ok1, ok2, ok3} !== 3'b111) begin fails++; $display("FAIL b2b_timeout: got %b want 111", {ok1, ok2, ok3}); end
    tests++;
    if (rxv_cnt[2] - v0 !== 2) begin fails++; $display("FAIL b2b_rxvalid_pulses: got %0d want 2", rxv_cnt[2] - v0); end
    tests++;
    if (last_high[2] !== 1) begin fails++; $display("FAIL b2b_csn_gap: got %0d want 1", last_high[2]); end
    tests++;
    if ({rx_hist1[2], rx_hist0[2]} !== 16'h0180) begin
      fails++; $display("FAIL b2b_words: got %h %h want 01 80", rx_hist1[2], rx_hist0[2]);
    end
    tests++;
    if (last_low[2] !== 17) begin fails++; $display("FAIL b2b_csn_low: got %0d want 17", last_low[2]); end
  endtask

  task automatic test_holdoff();
    int r0 = rises[0], v0 = rxv_cnt[0], bad = 0;
    bit ok1, seen;
    start_frame(0, 8'h5A, ok1);
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rxv_w[0]) begin
        seen = 1'b1;
        tx_valid[0] = 1'b0;
        break;
      end
      if (!busy_w[0] || tx_ready_w[0]) bad++;
      tx_data[0]  = 8'($urandom);
      tx_valid[0] = 1'($urandom_range(0, 1));
    end
    repeat (30) @(negedge clk);
    tests++;
    if ({ok1, seen} !== 2'b11) begin fails++; $display("FAIL hold_timeout: got %b want 11", {ok1, seen}); end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL hold_busy: got %0d cycles not busy want 0", bad); end
    tests++;
    if (rx_data[0] !== 8'h5A || mosi_bits[0] !== 8'h5A) begin
      fails++; $display("FAIL hold_word: got rx %h mosi %h want 5a 5a", rx_data[0], mosi_bits[0]);
    end
    tests++;
    if (rises[0] - r0 !== 8 || rxv_cnt[0] - v0 !== 1 || csn_w[0] !== 1'b1) begin
      fails++;
      $display("FAIL hold_single_frame: got rises %0d pulses %0d csn %b want 8 1 1",
               rises[0] - r0, rxv_cnt[0] - v0, csn_w[0]);
    end
  endtask

  task automatic test_width2();
    int r0 = rises[3], v0 = rxv_cnt[3];
    bit ok1, ok2;
    start_frame(3, 8'h02, ok1);
    tx_valid[3] = 1'b0;
    wait_rxv(3, v0, 1, ok2);
    wait_idle(3);
    tests++;
    if ({ok1, ok2} !== 2'b11) begin fails++; $display("FAIL w2_timeout: got %b want 11", {ok1, ok2}); end
    tests++;
    if (rx_data[3] !== 8'h02) begin fails++; $display("FAIL w2_rxdata: got %h want 02", rx_data[3]); end
    tests++;
    if (last_low[3] !== 5) begin fails++; $display("FAIL w2_csn_low: got %0d want 5", last_low[3]); end
    tests++;
    if (rises[3] - r0 !== 2) begin fails++; $display("FAIL w2_rises: got %0d want 2", rises[3] - r0); end
  endtask

  // Random frames on random instances against the frame-level model.
  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      int g = $urandom_range(0, NI - 1);
      int w = w_of(g);
      int d = d_of(g);
      logic [7:0] mask = 8'((1 << w) - 1);
      logic [7:0] word = 8'($urandom) & mask;
      logic [7:0] sl   = 8'($urandom);
      logic [7:0] exp_rx = (g == 1) ? sl : word;
      int r0 = rises[g], v0 = rxv_cnt[g];
      bit ok1, ok2;
      if (g == 1) preload_slave(sl);
      start_frame(g, word, ok1);
      tx_valid[g] = 1'b0;
      wait_rxv(g, v0, 1, ok2);
      wait_idle(g);
      tests++;
      if ({ok1, ok2} !== 2'b11) begin fails++; $display("FAIL rnd%0d_timeout: got %b want 11", n, {ok1, ok2}); end
      tests++;
      if (rx_data[g] !== exp_rx) begin fails++; $display("FAIL rnd%0d_rxdata[%0d]: got %h want %h", n, g, rx_data[g], exp_rx); end
      tests++;
      if ((mosi_bits[g] >> (8 - w)) !== word) begin
        fails++; $display("FAIL rnd%0d_mosi[%0d]: got %h want %h", n, g, mosi_bits[g] >> (8 - w), word);
      end
      tests++;
      if (last_low[g] !== d * (2 * w + 1) || rises[g] - r0 !== w) begin
        fails++;
        $display("FAIL rnd%0d_timing[%0d]: got low %0d rises %0d want %0d %0d", n, g,
                 last_low[g], rises[g] - r0, d * (2 * w + 1), w);
      end
      if (g == 1) begin
        tests++;
        if (slave_q !== word) begin fails++; $display("FAIL rnd%0d_slave: got %h want %h", n, slave_q, word); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    preload_slave(8'h00);
    test_loopback_a5();
    test_slave();
    test_reset_midframe();
    test_back_to_back();
    test_holdoff();
    test_width2();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
